// File: rtl/ex_tag_chk.sv
// EX-stage tag checker: extracts a variable-width tag field from one 32-bit half and compares it
// with the pattern value over a 2-stage pipeline, with trap request/ack and a mismatch counter.
module ex_tag_chk #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             exHold,
    input  logic             exFlush,
    input  logic             iValid,
    input  logic             iOpQ,
    input  logic             iTrapEn,
    input  logic [63:0]      valRs,
    input  logic [9:0]       valRi,
    output logic             oValid,
    output logic             oTagOk,
    output logic [7:0]       oFieldVal,
    output logic             oTrapReq,
    input  logic             iTrapAck,
    output logic             oBusy,
    output logic [CNT_W-1:0] oMisCnt
);

    typedef enum logic {StIdle, StReq} state_e;

    state_e state_q, state_d;

    logic [3:0]  dec_w;
    logic        dec_hi;
    logic [7:0]  dec_val;

    logic        s1_valid_q, s1_trap_en_q, s1_hi_q;
    logic [31:0] s1_half_q;
    logic [3:0]  s1_w_q;
    logic [7:0]  s1_val_q;

    logic        s2_valid_q, s2_ok_q;
    logic [7:0]  s2_field_q;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic        stall;
    logic        cap_mis;
    logic [8:0]  lo_mask;
    logic [7:0]  field_c;
    logic        match_c;

    // The leading one of the pattern sets the width; the bit just below it picks the side.
    always_comb begin
        dec_w   = 4'd0;
        dec_hi  = 1'b0;
        dec_val = 8'd0;
        if (valRi[9:6] == 4'd0) begin
            casez (valRi[5:2])
                4'b1???: begin dec_w = 4'd4; dec_hi = valRi[4]; dec_val = {4'd0, valRi[3:0]}; end
                4'b01??: begin dec_w = 4'd3; dec_hi = valRi[3]; dec_val = {5'd0, valRi[2:0]}; end
                4'b001?: begin dec_w = 4'd2; dec_hi = valRi[2]; dec_val = {6'd0, valRi[1:0]}; end
                4'b0001: begin dec_w = 4'd1; dec_hi = valRi[1]; dec_val = {7'd0, valRi[0]};   end
                default: ;
            endcase
        end else begin
            casez (valRi[9:6])
                4'b1???: begin dec_w = 4'd8; dec_hi = valRi[8]; dec_val = valRi[7:0];         end
                4'b01??: begin dec_w = 4'd7; dec_hi = valRi[7]; dec_val = {1'b0, valRi[6:0]}; end
                4'b001?: begin dec_w = 4'd6; dec_hi = valRi[6]; dec_val = {2'b0, valRi[5:0]}; end
                default: begin dec_w = 4'd5; dec_hi = valRi[5]; dec_val = {3'b0, valRi[4:0]}; end
            endcase
        end
    end

    always_comb begin
        lo_mask = (9'd1 << s1_w_q) - 9'd1;
        field_c = 8'd0;
        if (s1_w_q != 4'd0) begin
            if (s1_hi_q) field_c = s1_half_q[31:24] >> (4'd8 - s1_w_q);
            else         field_c = s1_half_q[7:0] & lo_mask[7:0];
        end
        match_c = (field_c == s1_val_q);
    end

    assign stall   = exHold | (state_q == StReq);
    assign cap_mis = s1_valid_q & ~match_c & ~stall & ~exFlush;

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (cap_mis && s1_trap_en_q) state_d = StReq;
            StReq:  if (iTrapAck) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        cnt_d = cnt_q;
        if (cap_mis && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            s1_valid_q   <= 1'b0;
            s1_trap_en_q <= 1'b0;
            s1_hi_q      <= 1'b0;
            s1_half_q    <= 32'd0;
            s1_w_q       <= 4'd0;
            s1_val_q     <= 8'd0;
            s2_valid_q   <= 1'b0;
            s2_ok_q      <= 1'b0;
            s2_field_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (!stall) begin
                s1_valid_q   <= iValid;
                s1_trap_en_q <= iTrapEn;
                s1_hi_q      <= dec_hi;
                s1_half_q    <= iOpQ ? valRs[63:32] : valRs[31:0];
                s1_w_q       <= dec_w;
                s1_val_q     <= dec_val;
                s2_valid_q   <= s1_valid_q;
                s2_ok_q      <= match_c;
                s2_field_q   <= field_c;
            end
            // Flush kills in-flight ops even while stalled; a pending trap stays pending.
            if (exFlush) begin
                s1_valid_q <= 1'b0;
                s2_valid_q <= 1'b0;
            end
        end
    end

    assign oValid    = s2_valid_q;
    assign oTagOk    = s2_ok_q;
    assign oFieldVal = s2_field_q;
    assign oTrapReq  = (state_q == StReq);
    assign oBusy     = (state_q == StReq);
    assign oMisCnt   = cnt_q;

endmodule

// File: tb/tb_ex_tag_chk.sv
// Directed and random-insert checks for ex_tag_chk: decode, pipeline latency, stall/flush,
// trap handshake and mismatch counting.
module tb_ex_tag_chk;

    logic        clock = 1'b0;
    logic        reset, exHold, exFlush, iValid, iOpQ, iTrapEn, iTrapAck;
    logic [63:0] valRs;
    logic [9:0]  valRi;
    logic        oValid, oTagOk, oTrapReq, oBusy;
    logic [7:0]  oFieldVal;
    logic [15:0] oMisCnt;

    int checks = 0;
    int failures = 0;

    ex_tag_chk #(.CNT_W(16)) dut (
        .clock(clock), .reset(reset), .exHold(exHold), .exFlush(exFlush), .iValid(iValid),
        .iOpQ(iOpQ), .iTrapEn(iTrapEn), .valRs(valRs), .valRi(valRi), .oValid(oValid),
        .oTagOk(oTagOk), .oFieldVal(oFieldVal), .oTrapReq(oTrapReq), .iTrapAck(iTrapAck),
        .oBusy(oBusy), .oMisCnt(oMisCnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic q, input logic te, input logic [63:0] rs,
                         input logic [9:0] ri);
        iValid  = v;
        iOpQ    = q;
        iTrapEn = te;
        valRs   = rs;
        valRi   = ri;
    endtask

    // Width is one less than the leading-one position of the pattern (none below bit 2).
    function automatic int pat_width(input logic [9:0] p);
        int b;
        b = -1;
        for (int i = 0; i < 10; i++) if (p[i]) b = i;
        return (b >= 2) ? b - 1 : 0;
    endfunction

    function automatic logic [7:0] pat_value(input logic [9:0] p);
        logic [7:0] v;
        int w;
        v = 8'd0;
        w = pat_width(p);
        for (int i = 0; i < w; i++) v[i] = p[i];
        return v;
    endfunction

    function automatic logic [63:0] tag_insert(input logic [63:0] d, input logic [9:0] p,
                                               input logic q);
        logic [31:0] h;
        int w;
        logic hi;
        h  = q ? d[63:32] : d[31:0];
        w  = pat_width(p);
        hi = (w > 0) ? p[w] : 1'b0;
        for (int i = 0; i < w; i++) begin
            if (hi) h[32-w+i] = p[i];
            else    h[i] = p[i];
        end
        return q ? {h, d[31:0]} : {d[63:32], h};
    endfunction

    task automatic run_op(input string tag, input logic q, input logic [63:0] rs,
                          input logic [9:0] ri, input logic exp_ok, input logic [7:0] exp_f);
        drive(1'b1, q, 1'b0, rs, ri);
        step;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        step;
        check({tag, "_valid"}, oValid, 1);
        check({tag, "_ok"}, oTagOk, exp_ok);
        check({tag, "_field"}, oFieldVal, exp_f);
    endtask

    logic [7:0]  got_q[$];
    logic [7:0]  k;
    logic [9:0]  p;
    logic        q;
    logic [63:0] d;
    int          idx;
    logic        hold;

    initial begin
        reset = 1'b1; exHold = 1'b0; exFlush = 1'b0; iTrapAck = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        step;
        step;
        check("rst_valid", oValid, 0);
        check("rst_ok", oTagOk, 0);
        check("rst_field", oFieldVal, 0);
        check("rst_trap", oTrapReq, 0);
        check("rst_busy", oBusy, 0);
        check("rst_cnt", oMisCnt, 0);
        reset = 1'b0;
        step;

        run_op("w4h", 1'b0, 64'h0000_0000_A000_0003, 10'h03A, 1'b1, 8'h0A);
        run_op("w2l", 1'b0, 64'h0000_0000_A000_0003, 10'h00B, 1'b1, 8'h03);
        run_op("w2l_q", 1'b1, 64'h0000_0003_0000_0000, 10'h00B, 1'b1, 8'h03);

        // Trapping mismatch: w8 H field 0x5D against value 0x5C.
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_5D00_0000, 10'h35C);
        step;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        step;
        check("trap_valid", oValid, 1);
        check("trap_ok", oTagOk, 0);
        check("trap_field", oFieldVal, 8'h5D);
        check("trap_req", oTrapReq, 1);
        check("trap_busy", oBusy, 1);
        check("trap_cnt", oMisCnt, 1);
        drive(1'b1, 1'b0, 1'b0, 64'd0, 10'h000);
        for (int i = 0; i < 3; i++) begin
            step;
            check("hold_valid", oValid, 1);
            check("hold_field", oFieldVal, 8'h5D);
            check("hold_req", oTrapReq, 1);
            check("hold_cnt", oMisCnt, 1);
        end
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        iTrapAck = 1'b1;
        step;
        iTrapAck = 1'b0;
        check("ack_req", oTrapReq, 0);
        check("ack_busy", oBusy, 0);
        step;
        check("ack_no_new_op", oValid, 0);
        check("ack_cnt", oMisCnt, 1);

        run_op("mis_notrap", 1'b0, 64'h0000_0000_5D00_0000, 10'h35C, 1'b0, 8'h5D);
        check("mis_notrap_req", oTrapReq, 0);
        check("mis_notrap_cnt", oMisCnt, 2);
        run_op("nofield", 1'b1, 64'hDEAD_BEEF_1234_5678, 10'h000, 1'b1, 8'h00);

        // Back-to-back stream with a 2-cycle hold; garbage driven during the hold must vanish.
        idx = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            hold   = (cyc == 2) || (cyc == 3);
            exHold = hold;
            if (hold) begin
                drive(1'b1, 1'b0, 1'b0, 64'h0000_0000_0000_00EE, 10'h2EE);
            end else if (idx < 4) begin
                k = 8'(8'h11 * (idx + 1));
                drive(1'b1, 1'b0, 1'b0, {56'd0, k}, {2'b10, k});
                idx++;
            end else begin
                drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
            end
            step;
            if (oValid && !hold) got_q.push_back(oFieldVal);
        end
        exHold = 1'b0;
        check("stream_count", got_q.size(), 4);
        for (int i = 0; i < got_q.size() && i < 4; i++) begin
            k = 8'(8'h11 * (i + 1));
            check("stream_order", got_q[i], k);
        end

        // Flush right behind a trapping mismatch.
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_5D00_0000, 10'h35C);
        step;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        exFlush = 1'b1;
        step;
        exFlush = 1'b0;
        check("flush_valid", oValid, 0);
        check("flush_req", oTrapReq, 0);
        step;
        check("flush_valid2", oValid, 0);
        check("flush_cnt", oMisCnt, 2);

        for (int n = 0; n < 24; n++) begin
            p = 10'($urandom_range(0, 1023));
            q = 1'($urandom_range(0, 1));
            d = {$urandom, $urandom};
            run_op("rnd", q, tag_insert(d, p, q), p, 1'b1, pat_value(p));
        end
        check("rnd_cnt", oMisCnt, 2);

        // Reset while a trap is pending.
        drive(1'b1, 1'b0, 1'b1, 64'h0000_0000_5D00_0000, 10'h35C);
        step;
        drive(1'b0, 1'b0, 1'b0, 64'd0, 10'd0);
        step;
        check("rreq_req", oTrapReq, 1);
        reset = 1'b1;
        step;
        reset = 1'b0;
        check("rreq_valid", oValid, 0);
        check("rreq_ok", oTagOk, 0);
        check("rreq_field", oFieldVal, 0);
        check("rreq_req0", oTrapReq, 0);
        check("rreq_busy", oBusy, 0);
        check("rreq_cnt", oMisCnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ex_tag_chk.md
Name: ex_tag_chk

Overview:
- Downstream companion to the EX-stage tag-insert (LDI-tag) unit.
- Takes a 64-bit value and the same 10-bit variable-width tag pattern the insert unit uses.
- Extracts the selected tag field from the low or high 32-bit half and compares it against the pattern value.
- Produces a 2-cycle pipelined match flag (SR.T source), the extracted field, an optional trap request with ack handshake, and a saturating mismatch counter.

Parameters:
CNT_W, 16, width of saturating mismatch counter

Ports:
clock  in  1  core clock
reset  in  1  synchronous, active-high reset
exHold  in  1  pipeline stall from core; freezes both stages
exFlush  in  1  kills in-flight ops (both stages)
iValid  in  1  op valid this cycle
iOpQ  in  1  0: check valRs[31:0]; 1: check valRs[63:32]
iTrapEn  in  1  mismatch raises trap request
valRs  in  64  tagged value
valRi  in  10  encoded tag pattern
oValid  out  1  result valid (stage 2)
oTagOk  out  1  field matched (1 also for "no field" patterns)
oFieldVal  out  8  extracted field, zero-extended
oTrapReq  out  1  trap request, held until ack
iTrapAck  in  1  trap unit accepts request
oBusy  out  1  trap pending; upstream must stall
oMisCnt  out  CNT_W  saturating count of mismatches

Behaviour:
Pattern decode (P=valRi, S=selected 32-bit half), width w, side L/H, value V = P[w-1:0]:
- P[9:6]==0, P[5:0]:
  - 0000zz: no field, match=1, field=0
  - 00010z: w1 L
  - 00011z: w1 H (S[31])
  - 0010zz: w2 L
  - 0011zz: w2 H
  - 010zzz: w3 L
  - 011zzz: w3 H
  - 10zzzz: w4 L
  - 11zzzz: w4 H
- Otherwise, P[9:5]:
  - 00010 / 00011: w5 L / H
  - 0010z / 0011z: w6 L / H
  - 010zz / 011zz: w7 L / H
  - 10zzz / 11zzz: w8 L / H
- L field = S[w-1:0]; H field = S[31:32-w]. match = (field == V).
- Inserting pattern P with the tag-insert unit then checking with the same P and iOpQ must always give match=1.

Pipeline:
- Stage 1 registers the selected half, mask, value and ctl (valid, trapEn).
- Stage 2 registers the compare result, field and valid.
- Latency 2: iValid at edge N -> oValid high after edge N+2.
- Internal stall = exHold | oBusy. While stalled, both stages hold their contents and inputs are ignored.
- exFlush clears both valid bits at the next edge and overrides stall. It does not cancel a trap already in REQ.

Trap FSM (IDLE, REQ):
- IDLE->REQ at the edge where stage 2 captures a valid, trapEn, mismatching op. oTrapReq and oBusy rise together with that oValid.
- REQ: oTrapReq=oBusy=1. Stage 2 output is held stable.
- REQ->IDLE on the edge with iTrapAck=1. The pipeline resumes the following cycle.
- iTrapAck in IDLE is ignored.

Counter:
- oMisCnt increments on each stage-2 capture of a valid mismatch (trapEn irrelevant).
- Saturates at all-ones. A held result is not recounted.

Reset (synchronous): all valids=0, FSM=IDLE, oValid=0, oTagOk=0, oFieldVal=0, oTrapReq=0, oBusy=0, oMisCnt=0. Reset mid-REQ drops oTrapReq at the next edge.

Simultaneous events:
- reset beats everything.
- exFlush with a trapping op entering stage 2: flush wins, no trap.
- iTrapAck and a new trapping op cannot coincide, because the pipeline is frozen in REQ.

Test Plan:
- valRs=0x00000000_A0000003, iOpQ=0, P=0x03A (w4 H, V=0xA) -> two cycles later oValid=1, oTagOk=1, oFieldVal=0x0A.
- Same valRs, P=0x00B (w2 L, V=3) -> oTagOk=1, oFieldVal=0x03. Repeat with iOpQ=1 and valRs=0x00000003_00000000 -> oTagOk=1.
- valRs[31:24]=0x5D, P=0x35C (w8 H, V=0x5C), iTrapEn=1:
  - oTagOk=0, oFieldVal=0x5D, oTrapReq=oBusy=1, oMisCnt=1.
  - Hold iTrapAck low 3 cycles -> outputs stable, a new iValid op is not accepted.
  - Pulse ack -> oTrapReq=0 next cycle.
- Same mismatch with iTrapEn=0 -> oTagOk=0, no trap, counter +1. P=0x000 with any valRs -> oTagOk=1, oFieldVal=0.
- Back-to-back ops with exHold high 2 cycles mid-stream -> results emerge in order, none dropped or duplicated.
- exFlush on the cycle after a mismatch op -> no oValid, no trap.
- Reset asserted while in REQ -> all outputs 0 next cycle.
- Random sweep: insert P into random data via reference model, check with same P/iOpQ -> oTagOk always 1.
